// File: rtl/pic_prog_loader_pkg.sv
// pic_prog_loader_pkg: shared defaults, FSM encoding and word-size helper for the program loader
package pic_prog_loader_pkg;
  localparam int PIC_INSTR_WIDTH_DEF = 12;
  localparam int L2_PIC_INSTR_MEM_DEPTH_DEF = 9;
  localparam int DWIDTH_DEF = 8;
  localparam int NUM_EXPOSED_REGS_DEF = 16;
  localparam int CYC_W_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM, S_RUN, S_DONE, S_ERROR
  } state_t;
  function automatic int bytes_per_word(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/pic_prog_loader_word_assembler.sv
// pic_word_assembler: packs little-endian bytes into instruction words, one registered pulse per word
module pic_word_assembler #(
  parameter int W = 12,
  parameter int BPW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic [7:0]   i_byte,
  output logic         o_last,
  output logic         o_word_valid,
  output logic [W-1:0] o_word
);
  logic [BPW*8-1:0] r_sh;
  logic [3:0] r_cnt;
  logic r_word_valid;
  logic [W-1:0] r_word;
  logic [(BPW+1)*8-1:0] w_cat;
  logic [BPW*8-1:0] w_full;
  assign w_cat = {i_byte, r_sh};
  assign w_full = w_cat[(BPW+1)*8-1:8];
  assign o_last = i_valid && r_cnt == 4'(BPW - 1);
  assign o_word_valid = r_word_valid;
  assign o_word = r_word;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
      r_cnt <= '0;
      r_word_valid <= 1'b0;
      r_word <= '0;
    end else begin
      r_word_valid <= o_last;
      if (i_clr) r_cnt <= '0;
      else if (i_valid) r_cnt <= o_last ? 4'd0 : r_cnt + 4'd1;
      if (i_valid) r_sh <= w_full;
      if (o_last) r_word <= w_full[W-1:0];
    end
  end
endmodule

// File: rtl/pic_prog_loader.sv
// pic_prog_loader: loads a checksummed byte-framed program into PIC instruction memory,
// then runs the cpu for a bounded number of clocks and snapshots its exposed registers.
module pic_prog_loader
  import pic_prog_loader_pkg::*;
#(
  parameter int PIC_INSTR_WIDTH = PIC_INSTR_WIDTH_DEF,
  parameter int L2_PIC_INSTR_MEM_DEPTH = L2_PIC_INSTR_MEM_DEPTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NUM_EXPOSED_REGS = NUM_EXPOSED_REGS_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 s_valid,
  input  logic [7:0]                           s_data,
  output logic                                 s_ready,
  input  logic [CYC_W-1:0]                     run_budget,
  output logic                                 mem_we,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0]    mem_waddr,
  output logic [PIC_INSTR_WIDTH-1:0]           mem_wdata,
  output logic                                 program_mode,
  output logic                                 cpu_rst,
  input  logic [DWIDTH*NUM_EXPOSED_REGS-1:0]   exposed_reg_file,
  output logic [DWIDTH*NUM_EXPOSED_REGS-1:0]   snapshot,
  output logic [CYC_W-1:0]                     cycles,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);
  localparam int BPW = bytes_per_word(PIC_INSTR_WIDTH);
  localparam logic [15:0] MAXW = 16'(2 ** L2_PIC_INSTR_MEM_DEPTH);
  state_t r_state, w_next;
  logic [7:0] r_nlo, r_sum;
  logic [15:0] r_n, r_wcnt;
  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] r_waddr;
  logic [CYC_W-1:0] r_budget, r_cycles;
  logic [DWIDTH*NUM_EXPOSED_REGS-1:0] r_snapshot;
  logic w_xfer, w_last, w_final, w_run_end, w_enter, w_hdr_bad;
  logic [15:0] w_n_in;
  logic [7:0] w_sum_next;
  assign w_xfer = s_valid && s_ready;
  assign w_n_in = {s_data, r_nlo};
  assign w_hdr_bad = w_n_in == 16'd0 || w_n_in > MAXW;
  assign w_sum_next = r_sum + s_data;
  assign w_final = w_last && r_wcnt == r_n - 16'd1;
  assign w_run_end = r_budget != '0 && r_cycles == r_budget;
  assign w_enter = w_next == S_HDR_LO && r_state != S_HDR_LO;
  assign mem_waddr = r_waddr;
  assign snapshot = r_snapshot;
  assign cycles = r_cycles;
  pic_word_assembler #(.W(PIC_INSTR_WIDTH), .BPW(BPW)) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_enter),
    .i_valid      (w_xfer && r_state == S_DATA && !abort),
    .i_byte       (s_data),
    .o_last       (w_last),
    .o_word_valid (mem_we),
    .o_word       (mem_wdata)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // abort outranks start and any byte transfer in the same cycle
  always_comb begin
    w_next = r_state;
    if (abort) w_next = S_IDLE;
    else case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_next = start ? S_HDR_LO : r_state;
      S_HDR_LO: w_next = w_xfer ? S_HDR_HI : r_state;
      S_HDR_HI: w_next = !w_xfer ? r_state : w_hdr_bad ? S_ERROR : S_DATA;
      S_DATA:   w_next = w_final ? S_CSUM : r_state;
      S_CSUM:   w_next = !w_xfer ? r_state : w_sum_next == 8'd0 ? S_RUN : S_ERROR;
      S_RUN:    w_next = w_run_end ? S_DONE : r_state;
      default:  w_next = S_IDLE;
    endcase
  end
  // cpu is held in reset on the halt cycle so it sees exactly run_budget clocks
  always_comb begin
    s_ready = r_state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM};
    program_mode = s_ready;
    busy = s_ready || r_state == S_RUN;
    cpu_rst = !(r_state == S_RUN && !w_run_end);
    done = r_state == S_DONE;
    error = r_state == S_ERROR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nlo <= '0;
      r_sum <= '0;
      r_n <= '0;
      r_wcnt <= '0;
      r_waddr <= '0;
      r_budget <= '0;
      r_cycles <= '0;
      r_snapshot <= '0;
    end else begin
      if (w_enter) begin
        r_sum <= '0;
        r_wcnt <= '0;
        r_cycles <= '0;
      end
      if (w_xfer && !abort) r_sum <= w_sum_next;
      if (r_state == S_HDR_LO && w_xfer) r_nlo <= s_data;
      if (r_state == S_HDR_HI && w_xfer) r_n <= w_n_in;
      if (w_last) begin
        r_wcnt <= r_wcnt + 16'd1;
        r_waddr <= r_wcnt[L2_PIC_INSTR_MEM_DEPTH-1:0];
      end
      if (r_state == S_CSUM && w_next == S_RUN) r_budget <= run_budget;
      if (r_state == S_RUN && w_next == S_RUN && r_cycles != '1) r_cycles <= r_cycles + 1'b1;
      if (r_state == S_RUN && w_next == S_DONE) r_snapshot <= exposed_reg_file;
    end
  end
endmodule

// File: tb/tb_pic_prog_loader.sv
// tb_pic_prog_loader: table-driven frame vectors plus abort, reset and start-while-busy sequences
module tb_pic_prog_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0;
  logic [7:0] s_data = 0;
  logic s_ready, mem_we, program_mode, cpu_rst, busy, done, error;
  logic [15:0] run_budget = 0;
  logic [8:0] mem_waddr;
  logic [11:0] mem_wdata;
  logic [127:0] exposed_reg_file, snapshot, last_snap;
  logic [15:0] cycles;
  logic [15:0] run_clk = 0;
  logic [20:0] wq[$];
  logic [20:0] eq[$];
  logic [7:0] bq[$];
  logic [7:0] fsum;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [15:0] n;
    logic [15:0] w0, w1, w2;
    logic [7:0]  ck_adj;
    logic [15:0] budget;
    bit          gaps;
    int          dly;
    bit          exp_err;
    int          exp_we;
  } vec_t;
  vec_t vt[7];

  pic_prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .run_budget(run_budget),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .program_mode(program_mode), .cpu_rst(cpu_rst),
    .exposed_reg_file(exposed_reg_file), .snapshot(snapshot), .cycles(cycles),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  // stand-in cpu: its register file reflects how many clocks it has run out of reset
  always @(posedge clk) if (!cpu_rst) run_clk <= run_clk + 16'd1;
  always @(negedge clk) if (mem_we) wq.push_back({mem_waddr, mem_wdata});

  function automatic logic [127:0] regs_of(input logic [15:0] k);
    return {16{k[7:0]}} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
  endfunction
  assign exposed_reg_file = regs_of(run_clk);

  function automatic logic [15:0] word_of(input vec_t v, input int i);
    return i == 0 ? v.w0 : i == 1 ? v.w1 : i == 2 ? v.w2 : 16'(i * 263 + 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    bq.push_back(b);
    fsum = fsum + b;
  endtask

  task automatic build_frame(input vec_t v);
    logic [15:0] wv;
    bq.delete();
    eq.delete();
    fsum = 0;
    push_b(v.n[7:0]);
    push_b(v.n[15:8]);
    if (v.exp_we > 0) begin
      for (int i = 0; i < int'(v.n); i++) begin
        wv = word_of(v, i);
        push_b(wv[7:0]);
        push_b(wv[15:8]);
        eq.push_back({9'(i), wv[11:0]});
      end
      bq.push_back(8'(8'd0 - fsum) + v.ck_adj);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1;
    s_data = b;
    g = 0;
    while (!s_ready && g < 20) begin
      tick();
      g++;
    end
    if (!s_ready) chk("s_ready wait", 0, 1);
    tick();
    s_valid = 0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int bw, g, m;
    logic [15:0] br;
    logic [127:0] es;
    build_frame(v);
    run_budget = v.budget;
    bw = wq.size();
    br = run_clk;
    repeat (v.dly) tick();
    start = 1;
    tick();
    start = 0;
    chk({nm, " enter"}, {busy, program_mode, cpu_rst, s_ready, done, error}, 6'b111100);
    foreach (bq[i]) send_byte(bq[i], v.gaps);
    g = 0;
    while (!(done || error) && g < int'(v.budget) + 100) begin
      tick();
      g++;
    end
    chk({nm, " done"}, done, !v.exp_err);
    chk({nm, " error"}, error, v.exp_err);
    chk({nm, " we count"}, wq.size() - bw, v.exp_we);
    m = 0;
    foreach (eq[i]) if (bw + i >= wq.size() || wq[bw + i] !== eq[i]) m++;
    chk({nm, " write data"}, m, 0);
    chk({nm, " cycles"}, cycles, v.exp_err ? 16'd0 : v.budget);
    chk({nm, " cpu clocks"}, run_clk - br, v.exp_err ? 16'd0 : v.budget);
    es = v.exp_err ? last_snap : regs_of(br + v.budget);
    chk({nm, " snapshot"}, snapshot, es);
    last_snap = es;
    chk({nm, " idle outs"}, {cpu_rst, s_ready, program_mode, busy}, 4'b1000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw;
    vt[0] = '{16'd3,   16'h00C5, 16'h0025, 16'h0A00, 8'd0, 16'd20, 1'b0, 0, 1'b0, 3};
    vt[1] = '{16'd3,   16'h00C5, 16'h0025, 16'h0A00, 8'd1, 16'd20, 1'b0, 0, 1'b1, 3};
    vt[2] = '{16'd0,   16'h0000, 16'h0000, 16'h0000, 8'd0, 16'd20, 1'b0, 0, 1'b1, 0};
    vt[3] = '{16'd513, 16'h0000, 16'h0000, 16'h0000, 8'd0, 16'd20, 1'b0, 0, 1'b1, 0};
    vt[4] = '{16'd3,   16'h00C5, 16'h0025, 16'h0A00, 8'd0, 16'd20, 1'b1, 3, 1'b0, 3};
    vt[5] = '{16'd1,   16'hF234, 16'h0000, 16'h0000, 8'd0, 16'd1,  1'b0, 0, 1'b0, 1};
    vt[6] = '{16'd512, 16'h0FFF, 16'h0001, 16'h0800, 8'd0, 16'd3,  1'b0, 0, 1'b0, 512};
    last_snap = 0;
    repeat (2) tick();
    chk("reset outs", {s_ready, mem_we, mem_waddr, mem_wdata, program_mode, cpu_rst, busy, done, error},
        {2'b00, 9'd0, 12'd0, 1'b0, 1'b1, 3'b000});
    chk("reset snapshot", snapshot, 0);
    chk("reset cycles", cycles, 0);
    rst = 0;
    tick();
    chk("idle after reset", {s_ready, cpu_rst, busy}, 3'b010);
    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));
    // unbounded run stopped by abort
    build_frame(vt[0]);
    run_budget = 0;
    start = 1;
    tick();
    start = 0;
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    repeat (100) tick();
    chk("b0 running", {busy, cpu_rst}, 2'b10);
    abort = 1;
    tick();
    abort = 0;
    chk("b0 abort outs", {busy, done, error, cpu_rst, program_mode, mem_we}, 6'b000100);
    chk("b0 cycles", cycles, 16'd100);
    chk("b0 snapshot hold", snapshot, last_snap);
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("abort+start", {busy, s_ready, program_mode, cpu_rst}, 4'b0001);
    // reset mid-load, with an ignored start while busy
    build_frame(vt[0]);
    run_budget = 20;
    bw = wq.size();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b0);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("start while busy", {busy, s_ready}, 2'b11);
    send_byte(bq[6], 1'b0);
    chk("pre-rst we count", wq.size() - bw, 2);
    chk("pre-rst word1", wq[bw + 1], {9'd1, 12'h025});
    chk("pre-rst addr/data", {mem_waddr, mem_wdata}, {9'd1, 12'h025});
    #3 rst = 1;
    #1;
    chk("async rst outs", {s_ready, mem_we, mem_waddr, mem_wdata, program_mode, cpu_rst, busy, done, error},
        {2'b00, 9'd0, 12'd0, 1'b0, 1'b1, 3'b000});
    chk("async rst snapshot", snapshot, 0);
    last_snap = 0;
    #2 rst = 0;
    tick();
    run_vec(vt[0], "after rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
